// File: rtl/cpu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, FSM state type and
// per-operation helpers for carry initialisation.
package cpu_pkg;

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpSub   = 3'd1;
  localparam logic [2:0] OpAnd   = 3'd2;
  localparam logic [2:0] OpOr    = 3'd3;
  localparam logic [2:0] OpXor   = 3'd4;
  localparam logic [2:0] OpPassB = 3'd5;
  localparam logic [2:0] OpIncA  = 3'd6;
  localparam logic [2:0] OpDecA  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic logic is_arith(logic [2:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpIncA) || (op == OpDecA);
  endfunction

  // SUB and INC_A start with carry 1 (two's complement +1 / increment).
  function automatic logic carry_init(logic [2:0] op);
    return (op == OpSub) || (op == OpIncA);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// One-bit full adder with a carry flop; the carry is preset by a synchronous
// load at the start of an operation and advances once per enabled cycle.
module serial_fa (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic load,
  input  logic cin_init,
  input  logic en,
  output logic sum,
  output logic cout
);

  logic carry_q;

  assign sum  = a ^ b ^ carry_q;
  assign cout = (a & b) | (a & carry_q) | (b & carry_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= cin_init;
    end else if (en) begin
      carry_q <= cout;
    end
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: operands are shifted LSB first through a single full adder,
// one bit per cycle, and the assembled result and flags are published on DONE.
module bit_serial_alu
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CntW-1:0]  cnt_q;
  logic             zacc_q;

  logic             a_bit;
  logic             b_bit;
  logic             fa_b;
  logic             fa_sum;
  logic             fa_cout;
  logic             fa_load;
  logic             fa_en;
  logic             res_bit;
  logic [WIDTH-1:0] res_next;

  assign a_bit    = a_sr[0];
  assign b_bit    = b_sr[0];
  assign fa_load  = (state_q == StIdle) && start;
  assign fa_en    = (state_q == StShift);
  assign res_next = {res_bit, res_sr};

  // Second adder input selects the operand transform for each arithmetic op.
  always_comb begin
    fa_b = b_bit;
    unique case (op_q)
      OpSub:   fa_b = ~b_bit;
      OpIncA:  fa_b = 1'b0;
      OpDecA:  fa_b = 1'b1;
      default: fa_b = b_bit;
    endcase
  end

  always_comb begin
    res_bit = fa_sum;
    unique case (op_q)
      OpAnd:   res_bit = a_bit & b_bit;
      OpOr:    res_bit = a_bit | b_bit;
      OpXor:   res_bit = a_bit ^ b_bit;
      OpPassB: res_bit = b_bit;
      default: res_bit = fa_sum;
    endcase
  end

  serial_fa u_serial_fa (
    .clk      (clk),
    .rst      (rst),
    .a        (a_bit),
    .b        (fa_b),
    .load     (fa_load),
    .cin_init (carry_init(op)),
    .en       (fa_en),
    .sum      (fa_sum),
    .cout     (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt_q   <= '0;
      zacc_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            cnt_q   <= '0;
            zacc_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next[WIDTH-1:1];
          zacc_q <= zacc_q | res_bit;
          cnt_q  <= cnt_q + CntW'(1);
          // Result and flags become visible only with the final bit.
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            done    <= 1'b1;
            result  <= res_next;
            flag_z  <= ~(zacc_q | res_bit);
            flag_c  <= is_arith(op_q) & fa_cout;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed and random checks of bit_serial_alu against an arithmetic reference.
module tb_bit_serial_alu;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] Mask = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc_cnt  = 0;
  int unsigned done_cyc = 0;

  bit_serial_alu #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_c (flag_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} from plain wide arithmetic.
  function automatic logic [WIDTH:0] model(input logic [2:0] f_op, input logic [WIDTH-1:0] fa,
                                           input logic [WIDTH-1:0] fb);
    logic [WIDTH-1:0] nb;
    int unsigned s;
    nb = ~fb;
    case (f_op)
      3'd0:    s = 32'(fa) + 32'(fb);
      3'd1:    s = 32'(fa) + 32'(nb) + 1;
      3'd2:    s = 32'(fa & fb);
      3'd3:    s = 32'(fa | fb);
      3'd4:    s = 32'(fa ^ fb);
      3'd5:    s = 32'(fb);
      3'd6:    s = 32'(fa) + 1;
      default: s = 32'(fa) + 32'(Mask);
    endcase
    return s[WIDTH:0];
  endfunction

  // Issues one op and returns at the negedge of the DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] t_op, input logic [WIDTH-1:0] t_a,
                       input logic [WIDTH-1:0] t_b);
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] prev;
    logic             busy_ok;
    logic             hold_ok;
    int               lat;
    m = model(t_op, t_a, t_b);
    @(negedge clk);
    prev  = result;
    start = 1'b1;
    op    = t_op;
    a     = t_a;
    b     = t_b;
    @(negedge clk);
    start   = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < int'(WIDTH) + 4) begin
      busy_ok &= (busy === 1'b1);
      hold_ok &= (result === prev);
      @(negedge clk);
      lat++;
    end
    done_cyc = cyc_cnt;
    check({tag, " latency"}, 32'(lat), 32'(WIDTH + 1));
    check({tag, " busy_in_shift"}, 32'(busy_ok), 32'd1);
    check({tag, " result_held"}, 32'(hold_ok), 32'd1);
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    check({tag, " result"}, 32'(result), 32'(m[WIDTH-1:0]));
    check({tag, " flag_c"}, 32'(flag_c), 32'(m[WIDTH]));
    check({tag, " flag_z"}, 32'(flag_z), 32'(m[WIDTH-1:0] == '0));
  endtask

  initial begin
    int unsigned t1;
    int          pulses;
    logic [2:0]  r_op;

    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    #1;
    check("reset outputs", 32'({busy, done, flag_z, flag_c, result}), 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    do_op("add_7f_01", 3'd0, 8'h7F, 8'h01);
    @(negedge clk);
    check("post_done done", 32'(done), 32'd0);
    check("post_done busy", 32'(busy), 32'd0);
    do_op("add_ff_01", 3'd0, 8'hFF, 8'h01);
    do_op("sub_05_07", 3'd1, 8'h05, 8'h07);
    do_op("sub_07_07", 3'd1, 8'h07, 8'h07);

    // XOR with start re-pulsed while busy: still exactly one completion.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    a     = 8'hA5;
    b     = 8'hFF;
    @(negedge clk);
    pulses = 0;
    for (int k = 1; k <= int'(WIDTH) + 12; k++) begin
      start = (k == 3 || k == 5);
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    start = 1'b0;
    check("xor done_pulses", 32'(pulses), 32'd1);
    check("xor result", 32'(result), 32'h5A);
    check("xor flag_c", 32'(flag_c), 32'd0);

    // Reset in the middle of SHIFT aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    a     = 8'h12;
    b     = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset outputs", 32'({busy, done, flag_z, flag_c, result}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < int'(WIDTH) + 4; k++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("midreset no_done", 32'(pulses), 32'd0);
    do_op("dec_00", 3'd7, 8'h00, 8'h00);

    // Back-to-back issue: completions exactly WIDTH+2 cycles apart.
    @(negedge clk);
    do_op("inc_ff", 3'd6, 8'hFF, 8'h00);
    t1 = done_cyc;
    do_op("or_00_00", 3'd3, 8'h00, 8'h00);
    check("b2b interval", done_cyc - t1, 32'(WIDTH + 2));

    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      do_op("random", r_op, 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
